priority_demux12b_stream: RTL
=============================

// Module: priority_demux12b_stream
//
// PURPOSE
// - Inverse of the 2:1 priority mux: routes a single 8-bit valid/ready stream to one or both of
//   two output channels, per beat, by a 2-bit route selector.
// - One register stage holds the beat; each output drains it independently. Broadcast beats
//   retire only after both sides accept.
// - Sits between an upstream producer and two operand consumers in the datapath.
//
// PARAMETERS
// - DATA_W  8   width of the data word on every channel
// - CNT_W   16  width of the per-output beat counters (used only with PDEMUX_STATS_EN)
//
// PORTS
// - clk         in   1       rising-edge clock
// - rst_n       in   1       asynchronous active-low reset
// - in_data     in   DATA_W  input word
// - in_sel      in   2       route: 00->OUT0, 01->OUT1, 10->OUT1, 11->BOTH (broadcast)
// - in_valid    in   1       input beat valid
// - in_ready    out  1       block accepts the beat this cycle
// - out0_data   out  DATA_W  channel 0 word
// - out0_valid  out  1       channel 0 beat valid
// - out0_ready  in   1       channel 0 consumer accepts
// - out1_data   out  DATA_W  channel 1 word
// - out1_valid  out  1       channel 1 beat valid
// - out1_ready  in   1       channel 1 consumer accepts
// - busy        out  1       a beat is held (pend0|pend1)
// - out0_cnt    out  CNT_W   beats delivered on ch0 (PDEMUX_STATS_EN only)
// - out1_cnt    out  CNT_W   beats delivered on ch1 (PDEMUX_STATS_EN only)
//
// BEHAVIOUR
// Reset (async, rst_n=0)
// - hold_q, pend0, pend1 and counters go to 0.
// - out*_valid=0, out*_data=0, busy=0. Recovery is synchronous to clk.
// - Reset mid-broadcast discards the held beat; nothing is replayed.
//
// Handshakes and latency
// - Transfer on any channel = valid & ready on the same rising edge.
// - Accepted beat is visible at outputs the next cycle (latency 1).
// - out*_valid = pend*. out0_data = out1_data = hold_q.
// - Once valid is asserted, it and the data stay stable until accepted.
// - in_ready = (~pend0 | out0_ready) & (~pend1 | out1_ready). This is combinational from
//   out*_ready and gives full throughput: one beat per cycle when consumers are ready.
//
// FSM (state derived from {pend1,pend0})
// - EMPTY   (00)
// - HOLD0   (01)
// - HOLD1   (10)
// - HOLDB   (11)
// - Pend set on accept: pend0 = (sel==00 | sel==11), pend1 = (sel!=00).
// - Each pend clears when its channel transfers; the set on a new accept wins.
// - Partial broadcast drain: HOLDB->HOLD0 or HOLD1; in_ready stays low until the last side
//   transfers.
// - Simultaneous drain and accept in the same cycle: hold_q is reloaded, pends are set from
//   the new sel, no bubble.
// - in_valid=0: state only drains; hold_q retains its value.
//
// CONFIGURATION
// - PDEMUX_STATS_EN defined:
//   - out0_cnt/out1_cnt ports exist and increment on each transfer of their channel.
//   - They wrap modulo 2^CNT_W and reset to 0.
// - PDEMUX_STATS_EN undefined: the counter ports and logic are absent. Routing is identical
//   cycle for cycle.
//
// STRUCTURE
// - Package pdemux_pkg:
//   - route_e enum {RT_OUT0=2'b00, RT_OUT1A=2'b01, RT_OUT1B=2'b10, RT_BOTH=2'b11}
//   - function route_to_pend(route_e) -> logic [1:0]
// - Sub-module pdemux_out_slot: one pend flag, its set/clear logic and the optional counter.
//   Instantiated twice. The top level holds hold_q and in_ready.
//
// TESTING
// - Reset: assert rst_n=0 mid-HOLDB -> all valid=0, busy=0, counters=0 immediately
//   (asynchronously).
// - Route: send 0xA5 with sel=00, then 0x3C with sel=01, both outputs ready ->
//   out0 gets 0xA5 at cycle+1, out1 gets 0x3C at cycle+2, no cross-delivery.
// - Broadcast stall: send 0x81 with sel=11, out0_ready=1, out1_ready=0 for 3 cycles ->
//   out0 takes it once, out1_valid held with 0x81, in_ready=0 until out1 accepts.
// - Throughput: 16 back-to-back beats with sel=10, out1_ready=1 ->
//   in_ready stays 1 throughout, 16 beats in 16 cycles, order preserved.
// - Backpressure: sel=00, out0_ready toggled 1/0 ->
//   out0_data stable while valid & !ready, no beat lost or duplicated.
// - Stats (PDEMUX_STATS_EN, CNT_W=4): 17 ch0 deliveries -> out0_cnt=1 (wrapped), out1_cnt=0.

Source files
------------

// File: rtl/priority_demux12b_stream_pkg.sv
// Shared types for the priority demux: route selector encoding, derived FSM state, route decode.
// Build option PDEMUX_STATS_EN adds per-output delivery counters (see top level).
package pdemux_pkg;

    typedef enum logic [1:0] {
        RT_OUT0  = 2'b00,
        RT_OUT1A = 2'b01,
        RT_OUT1B = 2'b10,
        RT_BOTH  = 2'b11
    } route_e;

    // State is {pend1,pend0}; no separate register exists for it.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_HOLD0 = 2'b01,
        ST_HOLD1 = 2'b10,
        ST_HOLDB = 2'b11
    } state_e;

    // Returns {pend1, pend0} for a freshly accepted beat.
    function automatic logic [1:0] route_to_pend(input route_e r);
        return {r != RT_OUT0, (r == RT_OUT0) || (r == RT_BOTH)};
    endfunction

endpackage

// File: rtl/priority_demux12b_stream_out_slot.sv
// One output channel of the demux: pending flag plus optional delivery counter.
// Counter present only when PDEMUX_STATS_EN is defined.
module pdemux_out_slot
`ifdef PDEMUX_STATS_EN
#(
    parameter int CNT_W = 16
)
`endif
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic             i_set,
    input  logic             i_ready,
`ifdef PDEMUX_STATS_EN
    output logic [CNT_W-1:0] o_cnt,
`endif
    output logic             o_pend
);

    logic r_pend;
    logic w_xfer;

    assign w_xfer = r_pend & i_ready;
    assign o_pend = r_pend;

    // A new accept overrides the clear from a same-cycle transfer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_pend <= 1'b0;
        else if (i_load)
            r_pend <= i_set;
        else if (w_xfer)
            r_pend <= 1'b0;
    end

`ifdef PDEMUX_STATS_EN
    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_cnt <= '0;
        else if (w_xfer)
            r_cnt <= r_cnt + 1'b1;
    end

    assign o_cnt = r_cnt;
`endif

endmodule

// File: rtl/priority_demux12b_stream.sv
// 1:2 valid/ready demux with broadcast; one holding register drained independently per side.
// Define PDEMUX_STATS_EN to add out0_cnt/out1_cnt delivery counters.
module priority_demux12b_stream
    import pdemux_pkg::*;
#(
    parameter int DATA_W = 8
`ifdef PDEMUX_STATS_EN
   ,parameter int CNT_W  = 16
`endif
)
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] in_data,
    input  logic [1:0]        in_sel,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] out0_data,
    output logic              out0_valid,
    input  logic              out0_ready,
    output logic [DATA_W-1:0] out1_data,
    output logic              out1_valid,
    input  logic              out1_ready,
`ifdef PDEMUX_STATS_EN
    output logic [CNT_W-1:0]  out0_cnt,
    output logic [CNT_W-1:0]  out1_cnt,
`endif
    output logic              busy
);

    logic [DATA_W-1:0] r_hold;
    logic [1:0]        w_pend;
    logic [1:0]        w_oready;
    logic [1:0]        w_set;
    logic              w_accept;
    state_e            w_state;

    assign w_oready = {out1_ready, out0_ready};
    assign w_set    = route_to_pend(route_e'(in_sel));

    // Accept only if every held side is empty or draining this cycle.
    assign in_ready = &(~w_pend | w_oready);
    assign w_accept = in_valid & in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_hold <= '0;
        else if (w_accept)
            r_hold <= in_data;
    end

`ifdef PDEMUX_STATS_EN
    logic [1:0][CNT_W-1:0] w_cnt;
`endif

    for (genvar g = 0; g < 2; g++) begin : g_slot
        pdemux_out_slot
`ifdef PDEMUX_STATS_EN
        #(.CNT_W(CNT_W))
`endif
        u_slot (
            .clk     (clk),
            .rst_n   (rst_n),
            .i_load  (w_accept),
            .i_set   (w_set[g]),
            .i_ready (w_oready[g]),
`ifdef PDEMUX_STATS_EN
            .o_cnt   (w_cnt[g]),
`endif
            .o_pend  (w_pend[g])
        );
    end

    assign w_state    = state_e'(w_pend);
    assign busy       = (w_state != ST_EMPTY);
    assign out0_valid = w_pend[0];
    assign out1_valid = w_pend[1];
    assign out0_data  = r_hold;
    assign out1_data  = r_hold;

`ifdef PDEMUX_STATS_EN
    assign out0_cnt = w_cnt[0];
    assign out1_cnt = w_cnt[1];
`endif

endmodule
